glb_write_stream: RTL
=====================

# glb_write_stream

Synthesizable GLB-side stream source that plays back up to two preloaded blocks onto the 17-bit ready/valid data channel consumed by a tile's memory core. Each block is a size header word followed by that many payload words. Playback is armed by the configuration `flush` pulse and starts a fixed number of cycles after `flush` falls. It is the transmit end of the GLB read path used in memory-core tests and system bring-up.

## Interface
- `NUM_BLOCKS`, 1 — blocks transmitted per run (1 or 2).
- `DEPTH`, 1024 — payload words per block buffer.
- `ADDR_W`, 10 — `$clog2(DEPTH)`.
- `START_DELAY`, 3 — idle cycles between flush fall and first valid.
- `clk` in 1 — clock; one clock domain.
- `rst_n` in 1 — reset, synchronous, active-low.
- `flush` in 1 — arm/abort strobe.
- `ld_en` in 1 — write `ld_data` to buffer `ld_blk` at `ld_addr`.
- `ld_size_en` in 1 — write `ld_size` as word count of buffer `ld_blk`.
- `ld_blk` in 1 — buffer select; must be 0 when `NUM_BLOCKS`=1.
- `ld_addr` in `ADDR_W` — load address.
- `ld_data` in 16 — load payload.
- `ld_size` in `ADDR_W+1` — block size, 0..`DEPTH`.
- `data` out 17 — stream word; [15:0] header/payload, [16] end-of-block marker.
- `valid` out 1 — `data` valid.
- `ready` in 1 — sink accepts.
- `done` out 1 — all blocks sent; sticky.
- `busy` out 1 — high in WAIT/HDR/DATA.

## Operation
- States: IDLE, WAIT, HDR, DATA, DONE.
- `flush_q` registers `flush`; fall = `flush_q & ~flush`; rise = `~flush_q & flush`.
- IDLE/DONE: loads accepted. A fall moves the FSM to WAIT and clears `done`, the block index and the word counter.
- WAIT: count `START_DELAY` cycles, then go to HDR. If `START_DELAY`=0, go from IDLE directly to HDR.
- HDR: `data` = {1'b0, 5'b0, size[blk]}, where the size field is zero-extended to 16 bits. `valid`=1.
  - On handshake (`valid & ready`) with size>0, go to DATA.
  - On handshake with size=0, go to the next block's HDR, or to DONE if this was the last block.
- DATA: `data` = {last, mem[blk][cnt]}, where `last` = (cnt == size−1).
  - `cnt` increments on each handshake.
  - On the handshake of the last word, go to the next block's HDR, or to DONE.
- Blocks are sent in order 0 then 1. When `NUM_BLOCKS`=1, block 1 is never sent.
- Loads (`ld_en`, `ld_size_en`) are ignored while `busy`.
- A `flush` rise while `busy` aborts the run:
  - next state IDLE, `valid` low next cycle, `done` stays 0;
  - buffers and sizes are kept;
  - the following fall restarts from block 0.
- A `flush` rise in IDLE/DONE changes no state; only the fall arms the run.
- Sizes above `DEPTH` are clamped to `DEPTH`.

## Timing
- Reset, sampled at a rising edge with `rst_n`=0:
  - `valid`=0, `data`=0, `done`=0, `busy`=0;
  - state IDLE, `flush_q`=0;
  - sizes reset to 0; buffer contents are undefined.
- `valid` and `data` are registered. While `valid & ~ready`, `data` holds stable and `valid` stays high (no retraction).
- Fall sampled at edge E: `valid` rises after edge E+`START_DELAY`+1, or after E when `START_DELAY`=0.
- Throughput: with `ready` held high, one word per cycle with no bubbles, including HDR→DATA and block→block transitions.
- Memory read is combinational on (blk, cnt_next), or prefetched, so the next word is presented in the cycle after a handshake.
- `done` rises after the edge that completes the final handshake. It holds until reset or the next fall.
- A run of a size-S block occupies S+1 handshakes.
- Simultaneous load and state change on the same edge as the fall: the load is accepted; the block starts with the updated contents.

## Test plan
- Reset mid-DATA: assert `rst_n`=0 for one edge during block 0 -> next cycle `valid`=0, `done`=0, `busy`=0, state IDLE.
- `NUM_BLOCKS`=1, size 4, words 0x0011..0x0014, `ready`=1, fall then `START_DELAY`=3:
  - stream is 0x00004, 0x00011, 0x00012, 0x00013, 0x10014 on consecutive cycles;
  - first valid at E+4;
  - `done` one cycle after the last word.
- `NUM_BLOCKS`=2, sizes 3 and 2:
  - stream is hdr 3, three words, hdr 2, two words, with zero gap cycles;
  - `data[16]` set only on the 3rd and 5th payload words.
- Random `ready` backpressure on a size-8 block -> `data` stable while `valid & ~ready`; no word dropped or duplicated; the received sequence matches the buffer.
- Size 0 on block 0, size 2 on block 1 -> 0x00000, 0x00002, w0, 0x1_w1.
- Abort: `flush` rises after 2 payload words -> `valid` low next cycle, `done`=0. The next fall replays from the header 0x00004; `ld_en` pulsed while `busy` does not alter the replay.

Source files
------------

// File: rtl/glb_write_stream_if.sv
// rtl/glb_write_stream_if.sv - 17-bit ready/valid stream carrying block headers and payload
interface glb_write_stream_if;
    logic [16:0] data;
    logic        valid;
    logic        ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/glb_write_stream.sv
// rtl/glb_write_stream.sv - plays back up to two preloaded blocks (size header + payload) onto a stream
module glb_write_stream #(
    parameter int NUM_BLOCKS  = 1,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int START_DELAY = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                ld_en,
    input  logic                ld_size_en,
    input  logic                ld_blk,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [15:0]         ld_data,
    input  logic [ADDR_W:0]     ld_size,
    glb_write_stream_if.master  strm,
    output logic                done,
    output logic                busy
);
    localparam int              SZ_W     = ADDR_W + 1;
    localparam int              WAIT_W   = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
    localparam logic [SZ_W-1:0] DEPTH_SZ = SZ_W'(DEPTH);
    localparam logic            LAST_BLK = 1'(NUM_BLOCKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HDR, S_DATA, S_DONE} state_t;

    state_t            r_state;
    logic              r_flush_q;
    logic              r_blk;
    logic [ADDR_W-1:0] r_cnt;
    logic [WAIT_W-1:0] r_wait;
    logic [SZ_W-1:0]   r_size [2];
    logic              r_valid;
    logic [16:0]       r_data;
    logic              r_done;
    logic [15:0]       r_mem [2][DEPTH];

    logic              w_fall;
    logic              w_rise;
    logic              w_hs;
    logic              w_ld_ok;
    logic [SZ_W-1:0]   w_size_ld;
    logic [SZ_W-1:0]   w_size_eff [2];
    logic [SZ_W-1:0]   w_cur_size;
    logic [SZ_W-1:0]   w_nxt_size;
    logic              w_last_word;
    logic              w_last_blk;
    state_t            w_state_nxt;
    logic              w_blk_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_done_nxt;
    logic              w_valid_nxt;
    logic [16:0]       w_data_nxt;

    // A size load on the arming edge is forwarded so the header already reflects it.
    always_comb begin
        w_fall        = r_flush_q & ~flush;
        w_rise        = ~r_flush_q & flush;
        w_hs          = r_valid & strm.ready;
        w_ld_ok       = (r_state == S_IDLE) || (r_state == S_DONE);
        w_size_ld     = (ld_size > DEPTH_SZ) ? DEPTH_SZ : ld_size;
        w_size_eff[0] = (ld_size_en && w_ld_ok && !ld_blk) ? w_size_ld : r_size[0];
        w_size_eff[1] = (ld_size_en && w_ld_ok &&  ld_blk) ? w_size_ld : r_size[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_flush_q <= 1'b0;
            r_blk     <= 1'b0;
            r_cnt     <= '0;
            r_wait    <= '0;
            r_size[0] <= '0;
            r_size[1] <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_flush_q <= flush;
            r_blk     <= w_blk_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wait    <= w_wait_nxt;
            r_size[0] <= w_size_eff[0];
            r_size[1] <= w_size_eff[1];
            r_valid   <= w_valid_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en && w_ld_ok)
            r_mem[ld_blk][ld_addr] <= ld_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_blk_nxt   = r_blk;
        w_cnt_nxt   = r_cnt;
        w_wait_nxt  = r_wait;
        w_done_nxt  = r_done;
        w_cur_size  = w_size_eff[r_blk];
        w_last_word = ({1'b0, r_cnt} == (w_cur_size - SZ_W'(1)));
        w_last_blk  = (r_blk == LAST_BLK);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_fall) begin
                    w_done_nxt  = 1'b0;
                    w_blk_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_wait_nxt  = '0;
                    w_state_nxt = (START_DELAY == 0) ? S_HDR : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait == WAIT_W'(START_DELAY))
                    w_state_nxt = S_HDR;
                else
                    w_wait_nxt = r_wait + WAIT_W'(1);
            end
            S_HDR: begin
                if (w_hs) begin
                    w_cnt_nxt = '0;
                    if (w_cur_size != '0) begin
                        w_state_nxt = S_DATA;
                    end else if (w_last_blk) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_blk_nxt = r_blk + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    if (w_last_word) begin
                        w_cnt_nxt = '0;
                        if (w_last_blk) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_HDR;
                            w_blk_nxt   = r_blk + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + ADDR_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Abort: buffers and sizes survive, the next fall replays from block 0.
        if (w_rise && !w_ld_ok)
            w_state_nxt = S_IDLE;
    end

    // Output word is registered from the next-state view so a new word follows every handshake.
    always_comb begin
        w_nxt_size  = w_size_eff[w_blk_nxt];
        w_valid_nxt = (w_state_nxt == S_HDR) || (w_state_nxt == S_DATA);
        w_data_nxt  = '0;
        case (w_state_nxt)
            S_HDR:   w_data_nxt = {1'b0, 16'(w_nxt_size)};
            S_DATA:  w_data_nxt = {({1'b0, w_cnt_nxt} == (w_nxt_size - SZ_W'(1))),
                                   r_mem[w_blk_nxt][w_cnt_nxt]};
            default: w_data_nxt = '0;
        endcase
        busy       = (r_state == S_WAIT) || (r_state == S_HDR) || (r_state == S_DATA);
        done       = r_done;
        strm.valid = r_valid;
        strm.data  = r_data;
    end
endmodule
